// File: rtl/ntt_stream_sequencer_if.sv
// Coefficient input stream and result output stream of ntt_stream_sequencer.
interface ntt_stream_sequencer_if #(
    parameter int WIDTH = 18
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, mode, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/ntt_stream_sequencer.sv
// Frame sequencer around the 8-point radix core: serial load with twiddles, fixed-latency capture, drain.
// Optional frame counter output enabled by defining NTT_SEQ_FRAME_COUNT_EN.
module ntt_stream_sequencer #(
    parameter int WIDTH         = 18,
    parameter int PS_LATENCY    = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   rst_n,
    ntt_stream_sequencer_if.slave  bus,
    input  logic                   tw_we,
    input  logic [5:0]             tw_addr,
    input  logic [WIDTH-1:0]       tw_wdata,
    output logic [WIDTH-1:0]       core_in,
    output logic [WIDTH-1:0]       core_w1,
    output logic [WIDTH-1:0]       core_w2,
    output logic [WIDTH-1:0]       core_w3,
    output logic                   core_mode,
    output logic                   core_streaming_mode,
    input  logic [WIDTH-1:0]       core_out,
    output logic                   busy
`ifdef NTT_SEQ_FRAME_COUNT_EN
    ,
    output logic [15:0]            frame_count
`endif
);
    localparam int         WAIT      = SETTLE_CYCLES + PS_LATENCY;
    localparam logic [4:0] WAIT_LAST = 5'(WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_tw [2][3][8];
    logic [WIDTH-1:0] r_buf [8];
    logic [WIDTH-1:0] r_core_in;
    logic [WIDTH-1:0] r_w1;
    logic [WIDTH-1:0] r_w2;
    logic [WIDTH-1:0] r_w3;
    logic             r_core_mode;
    logic             r_stream;
    logic [2:0]       r_idx;
    logic [2:0]       r_rd;
    logic [4:0]       r_cnt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_fire;
    logic             w_out_fire;
    logic             w_tw_mode;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && r_idx == 3'd7)
                    w_next = (WAIT == 0) ? S_CAPTURE : S_SETTLE;
            end
            S_SETTLE:  if (r_cnt == WAIT_LAST) w_next = S_CAPTURE;
            S_CAPTURE: if (r_cnt == 5'd7) w_next = S_DRAIN;
            S_DRAIN: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && r_rd == 3'd7) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = w_out_valid;
    assign bus.out_data        = w_out_valid ? r_buf[r_rd] : '0;
    assign w_fire              = bus.in_valid & w_in_ready;
    assign w_out_fire          = w_out_valid & bus.out_ready;
    // Word 0 must already use the incoming mode; later words use the latched one.
    assign w_tw_mode           = (r_state == S_IDLE) ? bus.mode : r_core_mode;
    assign busy                = (r_state != S_IDLE);
    assign core_in             = r_core_in;
    assign core_w1             = r_w1;
    assign core_w2             = r_w2;
    assign core_w3             = r_w3;
    assign core_mode           = r_core_mode;
    assign core_streaming_mode = r_stream;

    // Twiddle file and capture buffer keep their contents through reset.
    always_ff @(posedge clock) begin
        if (tw_we && tw_addr[4:3] != 2'd3)
            r_tw[tw_addr[5]][tw_addr[4:3]][tw_addr[2:0]] <= tw_wdata;
        if (r_state == S_CAPTURE)
            r_buf[r_cnt[2:0]] <= core_out;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_core_in   <= '0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_w3        <= '0;
            r_core_mode <= 1'b0;
            r_stream    <= 1'b0;
            r_idx       <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
        end else begin
            r_stream <= w_fire;
            if (w_fire) begin
                r_core_in <= bus.in_data;
                r_w1      <= r_tw[w_tw_mode][0][r_idx];
                r_w2      <= r_tw[w_tw_mode][1][r_idx];
                r_w3      <= r_tw[w_tw_mode][2][r_idx];
                r_idx     <= r_idx + 3'd1;
            end
            if (w_fire && r_state == S_IDLE)
                r_core_mode <= bus.mode;
            // One counter serves both the settle wait and the capture window.
            if ((r_state == S_SETTLE || r_state == S_CAPTURE) && w_next == r_state)
                r_cnt <= r_cnt + 5'd1;
            else
                r_cnt <= '0;
            if (w_out_fire)
                r_rd <= r_rd + 3'd1;
        end
    end

`ifdef NTT_SEQ_FRAME_COUNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)                        r_frame_cnt <= '0;
        else if (w_out_fire && r_rd == 3'd7) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_count = r_frame_cnt;
`endif
endmodule

// File: tb/tb_ntt_stream_sequencer.sv
// Randomized bench for ntt_stream_sequencer with a frame-level reference model and a stub radix core.
module tb_ntt_stream_sequencer;
    localparam int W       = 18;
    localparam int PS_LAT  = 1;
    localparam int SET_CYC = 1;
    // Cycles from the 8th accepted word to the first valid output word.
    localparam int LAT     = 1 + SET_CYC + PS_LAT + 8;

    logic         clock = 1'b0;
    logic         rst_n = 1'b1;
    logic         tw_we;
    logic [5:0]   tw_addr;
    logic [W-1:0] tw_wdata;
    logic [W-1:0] core_in, core_w1, core_w2, core_w3, core_out;
    logic         core_mode, core_streaming_mode, busy;
`ifdef NTT_SEQ_FRAME_COUNT_EN
    logic [15:0]  frame_count;
`endif

    always #5 clock = ~clock;

    ntt_stream_sequencer_if #(.WIDTH(W)) bus_if ();

    ntt_stream_sequencer #(.WIDTH(W), .PS_LATENCY(PS_LAT), .SETTLE_CYCLES(SET_CYC)) dut (
        .clock(clock), .rst_n(rst_n), .bus(bus_if),
        .tw_we(tw_we), .tw_addr(tw_addr), .tw_wdata(tw_wdata),
        .core_in(core_in), .core_w1(core_w1), .core_w2(core_w2), .core_w3(core_w3),
        .core_mode(core_mode), .core_streaming_mode(core_streaming_mode),
        .core_out(core_out), .busy(busy)
`ifdef NTT_SEQ_FRAME_COUNT_EN
        , .frame_count(frame_count)
`endif
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] tw_m [2][3][8];
    logic [W-1:0] exp_out [8];
    logic [W-1:0] fw [8];
    int           acc, outs_done, since8, frames;
    logic         pend_stream, fire_pending, frame_mode, core_fixed, exp_ov;
    logic [W-1:0] pend_in, pend_w1, pend_w2, pend_w3, prev_core_in;
    logic [W-1:0] stream_q[$], w1_q[$], got_q[$], ref_q[$];
    logic         mode_q[$];

    function automatic logic [W-1:0] core_fn(input logic [W-1:0] x, a, b, c);
        return x + a + (b ^ {c[W-2:0], 1'b0});
    endfunction

    function automatic logic [W-1:0] tw_val(input int m, input int s, input int i);
        return W'((m << 12) | (s << 8) | (i << 4) | 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stub core: collects streamed words, then returns one result per cycle
    // starting PS_LATENCY cycles after streaming_mode falls on the 8th word.
    logic [W-1:0] cbuf [8];
    logic [3:0]   ccnt, cemit;
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ccnt     <= 4'd0;
            cemit    <= 4'd8;
            core_out <= '0;
        end else if (core_streaming_mode && ccnt < 4'd8) begin
            cbuf[ccnt[2:0]] <= core_fixed ? W'(100 + 32'(ccnt)) : core_fn(core_in, core_w1, core_w2, core_w3);
            ccnt            <= ccnt + 4'd1;
        end else if (!core_streaming_mode && ccnt == 4'd8) begin
            core_out <= cbuf[0];
            cemit    <= 4'd1;
            ccnt     <= 4'd0;
        end else if (cemit < 4'd8) begin
            core_out <= cbuf[cemit[2:0]];
            cemit    <= cemit + 4'd1;
        end
    end

    // Frame-level reference model and per-cycle compare.
    initial begin
        acc = 0; outs_done = 0; since8 = -1; frames = 0;
        pend_stream = 1'b0; fire_pending = 1'b0; frame_mode = 1'b0; exp_ov = 1'b0;
        pend_in = '0; pend_w1 = '0; pend_w2 = '0; pend_w3 = '0; prev_core_in = '0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                acc = 0; outs_done = 0; since8 = -1; frames = 0;
                pend_stream = 1'b0; fire_pending = 1'b0; prev_core_in = core_in;
            end else begin
                if (since8 >= 0) since8++;
                exp_ov = (acc == 8) && (since8 >= LAT);
                check("in_ready", 32'(bus_if.in_ready), 32'(acc < 8));
                check("busy", 32'(busy), 32'(acc > 0));
                check("core_streaming_mode", 32'(core_streaming_mode), 32'(pend_stream));
                if (pend_stream) begin
                    check("core_in", 32'(core_in), 32'(pend_in));
                    check("core_w1", 32'(core_w1), 32'(pend_w1));
                    check("core_w2", 32'(core_w2), 32'(pend_w2));
                    check("core_w3", 32'(core_w3), 32'(pend_w3));
                    check("core_mode", 32'(core_mode), 32'(frame_mode));
                    stream_q.push_back(core_in);
                    w1_q.push_back(core_w1);
                    mode_q.push_back(core_mode);
                end else begin
                    check("core_in_hold", 32'(core_in), 32'(prev_core_in));
                end
                check("out_valid", 32'(bus_if.out_valid), 32'(exp_ov));
                if (exp_ov)
                    check("out_data", 32'(bus_if.out_data), 32'(exp_out[outs_done]));
`ifdef NTT_SEQ_FRAME_COUNT_EN
                check("frame_count", 32'(frame_count), 32'(frames & 16'hFFFF));
`endif
                // Predict what the coming clock edge does.
                prev_core_in = core_in;
                pend_stream  = 1'b0;
                fire_pending = bus_if.in_valid && (acc < 8);
                if (fire_pending) begin
                    if (acc == 0) frame_mode = bus_if.mode;
                    pend_in = bus_if.in_data;
                    pend_w1 = tw_m[frame_mode][0][acc];
                    pend_w2 = tw_m[frame_mode][1][acc];
                    pend_w3 = tw_m[frame_mode][2][acc];
                    exp_out[acc] = core_fixed ? W'(100 + acc) : core_fn(pend_in, pend_w1, pend_w2, pend_w3);
                    pend_stream = 1'b1;
                    acc++;
                    if (acc == 8) since8 = 0;
                end
                if (tw_we && tw_addr[4:3] != 2'd3)
                    tw_m[tw_addr[5]][tw_addr[4:3]][tw_addr[2:0]] = tw_wdata;
                if (exp_ov && bus_if.out_ready) begin
                    got_q.push_back(bus_if.out_data);
                    outs_done++;
                    if (outs_done == 8) begin
                        acc = 0; outs_done = 0; since8 = -1; frames++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tw_write(input logic [5:0] a, input logic [W-1:0] d);
        tw_we = 1'b1; tw_addr = a; tw_wdata = d;
        step();
        tw_we = 1'b0;
    endtask

    // gap: 0 none, 1 one idle cycle before each word, 2 random 0..2 idle cycles
    task automatic send_words(input int n, input logic m, input int gap);
        int t;
        for (int k = 0; k < n; k++) begin
            bus_if.in_valid = 1'b0;
            if (gap == 1) step();
            else if (gap == 2) repeat ($urandom_range(2, 0)) step();
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = fw[k];
            bus_if.mode     = (k == 0) ? m : 1'($urandom_range(1, 0));
            t = 0;
            do begin
                step();
                t++;
            end while (!fire_pending && t < 200);
            check("in_accept", 32'(fire_pending), 32'd1);
        end
        bus_if.in_valid = 1'b0;
    endtask

    // stall: 0 out_ready high, 1 random, 2 low for the first 5 drain cycles
    task automatic wait_done(input int stall);
        int t, held;
        t = 0; held = 0;
        while (acc != 0 && t < 400) begin
            if (stall == 0) bus_if.out_ready = 1'b1;
            else if (stall == 1) bus_if.out_ready = 1'($urandom_range(1, 0));
            else if (bus_if.out_valid && held < 5) begin
                bus_if.out_ready = 1'b0;
                held++;
            end else bus_if.out_ready = 1'b1;
            step();
            t++;
        end
        bus_if.out_ready = 1'b1;
        check("frame_done", 32'(acc == 0), 32'd1);
    endtask

    task automatic clear_q();
        stream_q.delete(); w1_q.delete(); got_q.delete(); mode_q.delete();
    endtask

    initial begin
        bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.mode = 1'b0; bus_if.out_ready = 1'b1;
        tw_we = 1'b0; tw_addr = '0; tw_wdata = '0; core_fixed = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stream", 32'(core_streaming_mode), 32'd0);
        check("rst_core_in", 32'(core_in), 32'd0);
        check("rst_core_w1", 32'(core_w1), 32'd0);
        check("rst_core_mode", 32'(core_mode), 32'd0);
        check("rst_out_data", 32'(bus_if.out_data), 32'd0);
        rst_n = 1'b1;
        step();

        for (int m = 0; m < 2; m++)
            for (int s = 0; s < 3; s++)
                for (int i = 0; i < 8; i++)
                    tw_write({1'(m), 2'(s), 3'(i)}, tw_val(m, s, i));

        // Abort a frame after three words.
        for (int k = 0; k < 8; k++) fw[k] = W'(k + 1);
        send_words(3, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_stream", 32'(core_streaming_mode), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Frame A: words 1..8, mode 0, back-to-back.
        clear_q();
        send_words(8, 1'b0, 0);
        wait_done(0);
        check("A_stream_len", 32'(stream_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < stream_q.size(); k++) begin
            check("A_core_in_lit", 32'(stream_q[k]), 32'(k + 1));
            check("A_w1_lit", 32'(w1_q[k]), 32'((k << 4) | 1));
        end
        ref_q = got_q;

        // Frame B: same words with a gap before every word.
        clear_q();
        send_words(8, 1'b0, 1);
        wait_done(0);
        check("B_out_len", 32'(got_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < got_q.size() && k < ref_q.size(); k++)
            check("B_vs_A", 32'(got_q[k]), 32'(ref_q[k]));

        // Frame C: core returns 100..107, downstream stalls for 5 cycles.
        core_fixed = 1'b1;
        for (int k = 0; k < 8; k++) fw[k] = W'($urandom);
        clear_q();
        send_words(8, 1'b0, 0);
        wait_done(2);
        core_fixed = 1'b0;
        check("C_out_len", 32'(got_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < got_q.size(); k++)
            check("C_out_lit", 32'(got_q[k]), 32'(100 + k));

        // Frame D: INTT bank.
        for (int k = 0; k < 8; k++) fw[k] = W'($urandom);
        clear_q();
        send_words(8, 1'b1, 0);
        wait_done(0);
        check("D_stream_len", 32'(w1_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < w1_q.size(); k++) begin
            check("D_mode_lit", 32'(mode_q[k]), 32'd1);
            check("D_w1_lit", 32'(w1_q[k]), 32'(32'h1001 | (k << 4)));
        end
`ifdef NTT_SEQ_FRAME_COUNT_EN
        check("D_frame_count_lit", 32'(frame_count), 32'd4);
`endif

        // Random frames with twiddle rewrites, gaps and downstream backpressure.
        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(3, 0)) tw_write(6'($urandom), W'($urandom));
            for (int k = 0; k < 8; k++) fw[k] = W'($urandom);
            send_words(8, 1'($urandom_range(1, 0)), 2);
            wait_done(1);
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ntt_stream_sequencer.md
Name: ntt_stream_sequencer

Overview:
- Frame-level controller placed directly in front of and behind the 8-point combined radix core.
- Accepts 8 coefficients per frame on a valid/ready input and streams them serially into the core, with matching twiddle words from an internal twiddle register file.
- Drives the core's streaming_mode, captures the 8 serial results, and re-emits them on a valid/ready output.

Parameters:
- WIDTH, 18, coefficient/twiddle word width; must match the core.
- PS_LATENCY, 1, cycles from streaming_mode deassertion to result word 0 on output_core_stream (range 0-7).
- SETTLE_CYCLES, 1, idle cycles after the last load before capture starts (range 0-15).

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  coefficient word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts in_data.
- mode  in  1  0=NTT, 1=INTT; sampled on first accepted word of a frame.
- tw_we  in  1  twiddle write strobe.
- tw_addr  in  6  {mode[5], stage[4:3] (0..2), index[2:0]}; stage 3 writes ignored.
- tw_wdata  in  WIDTH  twiddle write data.
- core_in  out  WIDTH  to core input_core_stream.
- core_w1 / core_w2 / core_w3  out  WIDTH each  to core weight_1/2/3_stream.
- core_mode  out  1  to core mode.
- core_streaming_mode  out  1  to core streaming_mode.
- core_out  in  WIDTH  from core output_core_stream.
- out_data  out  WIDTH  result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; core_streaming_mode=0.
  - All counters are 0.
  - core_in, core_w1, core_w2, core_w3, out_data are 0; core_mode=0.
  - Twiddle file contents are preserved across reset.
- Twiddle file: 48 entries × WIDTH.
  - Writes take effect the cycle after tw_we.
  - A write and a read of the same entry in the same cycle return the old value.
- States: IDLE -> LOAD -> SETTLE -> CAPTURE -> DRAIN -> IDLE.
- IDLE:
  - in_ready=1.
  - A fire (in_valid & in_ready) latches mode into core_mode, writes word 0, sets idx=1, goes to LOAD.
- LOAD:
  - in_ready=1 while idx<8.
  - On every fire, registered for one cycle:
    - core_in = in_data.
    - core_w1/w2/w3 = twiddle[mode][0/1/2][idx].
    - core_streaming_mode = 1.
  - On cycles with no fire, core_streaming_mode=0 and core_in/core_w* hold.
  - Word order is index 0 first.
  - After the 8th fire, go to SETTLE; in_ready drops in the same cycle.
- SETTLE:
  - core_streaming_mode=0.
  - Wait SETTLE_CYCLES cycles, then PS_LATENCY further cycles, then go to CAPTURE.
- CAPTURE:
  - Exactly 8 consecutive cycles; core_out is written into capture buffer[0..7] in order.
  - No stall is possible, because the core stream cannot be paused.
- DRAIN:
  - out_valid=1 and out_data=buffer[rd].
  - rd advances on out_valid & out_ready.
  - After the 8th transfer: out_valid=0 the next cycle, go to IDLE.
  - in_ready=0 throughout DRAIN. The next frame's first word can be accepted the cycle after the last output transfer.
- out_ready low: out_valid and out_data hold stable.
- Counters: idx and rd are 3-bit and wrap 7->0 at the end of a frame. Arithmetic is pure data movement; there is no modular math in this block.
- Reset mid-frame: the frame is aborted immediately and no partial output is produced.
- mode changes mid-frame are ignored.

Optional Feature:
- Macro NTT_SEQ_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_count (16 bits), reset 0.
  - Increments on the last DRAIN transfer and wraps 0xFFFF->0.
- Undefined:
  - No port and no counter logic.

Test Plan:
- Reset mid-LOAD after 3 words:
  - Expected: out_valid=0, in_ready=1, busy=0, core_streaming_mode=0 immediately.
  - Expected: the next full frame produces correct output.
- Twiddle load then frame, mode=0, inputs 1..8, in_valid held high:
  - Expected: core_in shows 1..8 on 8 consecutive cycles with core_streaming_mode=1.
  - Expected: core_w1 carries twiddle[0][0][0..7].
- Gapped input (in_valid toggling 1,0,1,...):
  - Expected: core_streaming_mode pulses only on fire cycles.
  - Expected: core_in holds on gap cycles.
  - Expected: output matches the ungapped run.
- Core model returning 100..107 on core_out, PS_LATENCY=1, SETTLE_CYCLES=1:
  - Expected: capture begins exactly 2 cycles after the 8th fire.
  - Expected: out_data sequence is 100..107.
- out_ready low for 5 cycles during DRAIN:
  - Expected: out_data stable, no word lost or duplicated, in_ready=0 until the last transfer.
- mode=1 frame after mode=0 frame:
  - Expected: core_mode=1 and weights taken from the INTT bank.
  - With NTT_SEQ_FRAME_COUNT_EN defined: expected frame_count=2.
